// File: rtl/seven_seg_scan_driver_if.sv
// Bus between the score/game logic and the 7-segment scan driver.
// Writer side: enable, wr_en/wr_idx/wr_code buffer writes, blink/dp masks.
// Display side: seg_out {a,b,c,d,e,f,g,dp}, one-hot digit_sel, frame_start.
interface seven_seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned IDX_W      = 3
);
    logic                  enable;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [7:0]            wr_code;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [7:0]            seg_out;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  frame_start;

    modport master (
        output enable, wr_en, wr_idx, wr_code, blink_mask, dp_mask,
        input  seg_out, digit_sel, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_idx, wr_code, blink_mask, dp_mask,
        output seg_out, digit_sel, frame_start
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with per-digit blink and dp masks.
// Ports: clk, rst (sync, active-high), bus (slave modport): enable, buffer
// write port (wr_en/wr_idx/wr_code), blink_mask, dp_mask in; registered
// seg_out, digit_sel and frame_start out (1 cycle after the state they show).
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 250,
    parameter int unsigned IDX_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int unsigned SEL_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int unsigned PRESC_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0]  BLANK   = 8'd34;

    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;
    logic               blink_phase, blink_phase_nxt;
    logic               wrapped, wrapped_nxt;
    logic [7:0]         digit_buf [NUM_DIGITS];

    logic               wr_ok_c;
    logic [SEL_W-1:0]   wr_sel_c;
    logic [7:0]         seg_c;
    logic [NUM_DIGITS-1:0] sel_c;

    // Glyph code to segment pattern, bit 7 = a ... bit 0 = dp.
    function automatic logic [7:0] glyph(input logic [7:0] code);
        case (code)
            8'd0:  return 8'hFC;  8'd1:  return 8'h60;  8'd2:  return 8'hDA;
            8'd3:  return 8'hF2;  8'd4:  return 8'h66;  8'd5:  return 8'hB6;
            8'd6:  return 8'hBE;  8'd7:  return 8'hE4;  8'd8:  return 8'hFE;
            8'd9:  return 8'hF6;  8'd10: return 8'hEE;  8'd11: return 8'h3E;
            8'd12: return 8'h34;  8'd13: return 8'h7A;  8'd14: return 8'h9E;
            8'd15: return 8'h8E;  8'd16: return 8'hBC;  8'd17: return 8'h6E;
            8'd18: return 8'h0C;  8'd19: return 8'h70;  8'd20: return 8'h0E;
            8'd21: return 8'h1C;  8'd22: return 8'h2A;  8'd23: return 8'h3A;
            8'd24: return 8'hCE;  8'd25: return 8'hE6;  8'd26: return 8'h0A;
            8'd27: return 8'hB6;  8'd28: return 8'h1E;  8'd29: return 8'h38;
            8'd30: return 8'h38;  8'd31: return 8'h66;  8'd32: return 8'hDA;
            8'd33: return 8'h6C;  8'd34: return 8'h00;  8'd35: return 8'hFF;
            8'd36: return 8'h02;
            default: return 8'hFF;
        endcase
    endfunction

    // Scan sequencing: prescaler -> digit index -> frame counter -> blink phase.
    // wrapped remembers an index wrap until the digit-0 output edge emits it,
    // so frame_start lines up with digit_sel showing digit 0 even across a pause.
    always_comb begin
        presc_nxt       = presc;
        idx_nxt         = idx;
        frame_cnt_nxt   = frame_cnt;
        blink_phase_nxt = blink_phase;
        wrapped_nxt     = wrapped;
        if (bus.enable) begin
            wrapped_nxt = 1'b0;
            if (presc == PRESC_W'(SCAN_DIV - 1)) begin
                presc_nxt = '0;
                if (idx == SEL_W'(NUM_DIGITS - 1)) begin
                    idx_nxt     = '0;
                    wrapped_nxt = 1'b1;
                    if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt_nxt   = '0;
                        blink_phase_nxt = ~blink_phase;
                    end else begin
                        frame_cnt_nxt = frame_cnt + FRAME_W'(1);
                    end
                end else begin
                    idx_nxt = idx + SEL_W'(1);
                end
            end else begin
                presc_nxt = presc + PRESC_W'(1);
            end
        end
    end

    // Display decode from the pre-edge index and buffer; blink beats dp.
    always_comb begin
        seg_c = glyph(digit_buf[idx]) | {7'b0, bus.dp_mask[idx]};
        if (blink_phase && bus.blink_mask[idx]) begin
            seg_c = 8'h00;
        end
        sel_c = NUM_DIGITS'(1) << idx;
    end

    always_comb begin
        wr_ok_c  = bus.wr_en && (32'(bus.wr_idx) < NUM_DIGITS);
        wr_sel_c = SEL_W'(bus.wr_idx);
    end

    // Scan state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            presc           <= '0;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            wrapped         <= 1'b0;
            bus.seg_out     <= 8'h00;
            bus.digit_sel   <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            idx             <= idx_nxt;
            presc           <= presc_nxt;
            frame_cnt       <= frame_cnt_nxt;
            blink_phase     <= blink_phase_nxt;
            wrapped         <= wrapped_nxt;
            bus.seg_out     <= bus.enable ? seg_c : 8'h00;
            bus.digit_sel   <= bus.enable ? sel_c : '0;
            bus.frame_start <= bus.enable && wrapped;
        end
    end

    // Glyph-code buffer; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_buf[i] <= BLANK;
            end
        end else if (wr_ok_c) begin
            digit_buf[wr_sel_c] <= bus.wr_code;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned IW = 3;

    logic clk = 1'b0;
    logic rst;

    seven_seg_scan_driver_if #(.NUM_DIGITS(ND), .IDX_W(IW)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] idx;
        logic [7:0]    code;
        logic [7:0]    seg;
    } vec_t;

    vec_t       tv [14];
    logic [7:0] exp_seg [ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [IW-1:0] i, input logic [7:0] c);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = i;
        bus.wr_code = c;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Advance at least one edge, then until digit d is on (bounded).
    task automatic wait_digit(input int d);
        logic [3:0] tgt;
        int n;
        tgt = 4'(1) << d;
        n = 0;
        tick();
        while (bus.digit_sel !== tgt && n < 24) begin
            tick();
            n++;
        end
        check("wait_digit_sel", 32'(bus.digit_sel), 32'(tgt));
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        tick();
        while (bus.frame_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("wait_frame_start", 32'(bus.frame_start), 32'd1);
    endtask

    task automatic check_dark(input string name);
        check({name, "_seg"}, 32'(bus.seg_out), 32'h0);
        check({name, "_sel"}, 32'(bus.digit_sel), 32'h0);
        check({name, "_fs"},  32'(bus.frame_start), 32'h0);
    endtask

    initial begin
        logic [3:0] exp_sel;
        logic       exp_fs;
        logic [7:0] s;
        int d;
        int ph;

        tv[0]  = '{3'd0, 8'd0,   8'hFC};
        tv[1]  = '{3'd1, 8'd1,   8'h60};
        tv[2]  = '{3'd2, 8'd2,   8'hDA};
        tv[3]  = '{3'd3, 8'd3,   8'hF2};
        tv[4]  = '{3'd0, 8'd36,  8'h02};
        tv[5]  = '{3'd1, 8'd37,  8'hFF};
        tv[6]  = '{3'd2, 8'd255, 8'hFF};
        tv[7]  = '{3'd3, 8'd16,  8'hBC};
        tv[8]  = '{3'd0, 8'd8,   8'hFE};
        tv[9]  = '{3'd1, 8'd9,   8'hF6};
        tv[10] = '{3'd2, 8'd34,  8'h00};
        tv[11] = '{3'd3, 8'd35,  8'hFF};
        tv[12] = '{3'd1, 8'd10,  8'hEE};
        tv[13] = '{3'd2, 8'd27,  8'hB6};

        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_idx     = '0;
        bus.wr_code    = 8'h00;
        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        tick();
        tick();
        check_dark("reset");

        // Free-running scan from reset with a blank buffer.
        rst        = 1'b0;
        bus.enable = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp_sel = 4'(1) << (((k - 1) / 4) % 4);
            exp_fs  = (k > 1) && ((k - 1) % 16 == 0);
            check("scan_sel", 32'(bus.digit_sel), 32'(exp_sel));
            check("scan_fs",  32'(bus.frame_start), 32'(exp_fs));
            check("scan_seg", 32'(bus.seg_out), 32'h0);
        end

        // Glyph decode table through the live scan.
        for (int i = 0; i < 14; i++) begin
            write(tv[i].idx, tv[i].code);
            wait_digit(int'(tv[i].idx));
            check("glyph", 32'(bus.seg_out), 32'(tv[i].seg));
            exp_seg[tv[i].idx[1:0]] = tv[i].seg;
        end

        // Write to the displayed digit mid-dwell.
        write(3'd0, 8'd3);
        exp_seg[0] = 8'hF2;
        wait_fs();
        check("pre_write_seg", 32'(bus.seg_out), 32'hF2);
        write(3'd0, 8'd9);
        check("write_edge_seg", 32'(bus.seg_out), 32'hF2);
        check("write_edge_sel", 32'(bus.digit_sel), 32'h1);
        tick();
        check("after_write_seg", 32'(bus.seg_out), 32'hF6);
        check("after_write_sel", 32'(bus.digit_sel), 32'h1);
        exp_seg[0] = 8'hF6;

        // Out-of-range index must not alias onto a real digit.
        write(3'd5, 8'd0);
        for (int i = 0; i < 4; i++) begin
            wait_digit(i);
            check("oob_write_seg", 32'(bus.seg_out), 32'(exp_seg[i]));
        end

        // Pause mid-digit2, then resume the remaining dwell.
        wait_fs();
        for (int i = 0; i < 8; i++) tick();
        check("pause_entry_sel", 32'(bus.digit_sel), 32'h4);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_dark("paused");
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("resume_sel", 32'(bus.digit_sel), 32'h4);
            check("resume_seg", 32'(bus.seg_out), 32'(exp_seg[2]));
        end
        tick();
        check("resume_next_sel", 32'(bus.digit_sel), 32'h8);

        // Reset mid-scan with a concurrent write; buffer returns to blank.
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 3'd1;
        bus.wr_code = 8'd8;
        tick();
        check_dark("mid_reset");
        bus.wr_en = 1'b0;
        rst       = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_sel = 4'(1) << (((k - 1) / 4) % 4);
            check("post_reset_sel", 32'(bus.digit_sel), 32'(exp_sel));
            check("post_reset_seg", 32'(bus.seg_out), 32'h0);
        end

        // Blink and dp masks from a fresh reset.
        rst        = 1'b1;
        bus.enable = 1'b0;
        tick();
        rst = 1'b0;
        write(3'd0, 8'd5);
        write(3'd1, 8'd8);
        write(3'd2, 8'd2);
        write(3'd3, 8'd3);
        check_dark("disabled_writes");
        bus.blink_mask = 4'b0011;
        bus.dp_mask    = 4'b0101;
        bus.enable     = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            d  = ((k - 1) / 4) % 4;
            ph = ((k - 1) / 32) % 2;
            case (d)
                0:       s = (ph == 1) ? 8'h00 : 8'hB7;
                1:       s = (ph == 1) ? 8'h00 : 8'hFE;
                2:       s = 8'hDB;
                default: s = 8'hF2;
            endcase
            exp_sel = 4'(1) << d;
            check("blink_sel", 32'(bus.digit_sel), 32'(exp_sel));
            check("blink_seg", 32'(bus.seg_out), 32'(s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
